// File: rtl/rr_arbiter10_pkg.sv
// Shared constants, state encoding and code decode
// for the 10-way round-robin arbiter.
package rr_arbiter10_pkg;

  localparam int N_REQ  = 10;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Code k+1 selects bit k; 0 and 11..15 give all-zero
  function automatic logic [N_REQ-1:0] code2onehot(
    input logic [CODE_W-1:0] code
  );
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (code == CODE_W'(k + 1)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter10_if.sv
// Request/grant bundle between the requesters and
// the round-robin arbiter.
interface rr_arbiter10_if;
  import rr_arbiter10_pkg::*;

  logic              i_en;
  logic [N_REQ-1:0]  i_req;
  logic              i_release;
  logic [CODE_W-1:0] o_grant_code;
  logic [N_REQ-1:0]  o_grant;
  logic              o_valid;
  logic              o_timeout;

  modport master (
    output i_en, i_req, i_release,
    input  o_grant_code, o_grant, o_valid, o_timeout
  );

  modport slave (
    input  i_en, i_req, i_release,
    output o_grant_code, o_grant, o_valid, o_timeout
  );

endinterface

// File: rtl/rr_arbiter10_pick.sv
// Circular-priority picker: first set request
// strictly after ptr, wrapping modulo 10.
module rr_pick10
  import rr_arbiter10_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] idx,
  output logic              hit
);

  logic [CODE_W-1:0] w_j;

  // Scan farthest-first so the nearest hit wins
  always_comb begin
    idx = '0;
    hit = 1'b0;
    w_j = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_j = CODE_W'((int'(ptr) + i) % N_REQ);
      if (req[w_j]) begin
        idx = w_j;
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter10.sv
// Round-robin arbiter with hold/release handshake,
// forced dead cycle between owners and hold watchdog.
module rr_arbiter10
  import rr_arbiter10_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rr_arbiter10_if.slave   bus
);

  localparam int CNT_W =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] r_ptr;
  logic [CODE_W-1:0] w_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt;
  logic              r_tmo;
  logic              w_tmo;
  logic [CODE_W-1:0] w_idx;
  logic              w_hit;
  logic              w_rel;
  logic              w_expire;

  rr_pick10 u_pick (
    .req (bus.i_req),
    .ptr (r_ptr),
    .idx (w_idx),
    .hit (w_hit)
  );

  // r_ptr holds the owner index while in GRANT
  assign w_rel =
    bus.i_release || !bus.i_req[r_ptr];
  assign w_expire =
    (MAX_HOLD != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_code  <= CODE_NONE;
      r_ptr   <= CODE_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_code  <= w_code;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_tmo   <= w_tmo;
    end
  end

  always_comb begin
    w_nxt  = r_state;
    w_code = r_code;
    w_ptr  = r_ptr;
    w_cnt  = r_cnt;
    w_tmo  = 1'b0;
    unique case (1'b1)
      (r_state == GRANT): begin
        if (r_cnt != CNT_MAX) w_cnt = r_cnt + 1'b1;
        // A real release beats a coincident timeout
        if (w_rel || w_expire) begin
          w_nxt  = GAP;
          w_code = CODE_NONE;
          w_tmo  = !w_rel;
        end
      end
      default: begin
        w_nxt  = IDLE;
        w_code = CODE_NONE;
        if (bus.i_en && w_hit) begin
          w_nxt  = GRANT;
          w_code = w_idx + CODE_W'(1);
          w_ptr  = w_idx;
          w_cnt  = '0;
        end
      end
    endcase
  end

  always_comb begin
    bus.o_grant_code = r_code;
    bus.o_grant      = code2onehot(r_code);
    bus.o_valid      = (r_code != CODE_NONE);
    bus.o_timeout    = r_tmo;
  end

endmodule

// File: tb/tb_rr_arbiter10.sv
// Scoreboard bench for rr_arbiter10: directed
// scenarios plus random traffic vs an owner model.
module tb_rr_arbiter10;
  import rr_arbiter10_pkg::*;

  localparam int MH = 4;

  typedef struct {
    int code;
    bit tmo;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter10_if u_if ();

  rr_arbiter10 #(.MAX_HOLD(MH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  // Model: who owns the resource, who won last,
  // and how many cycles the grant has been shown
  int m_owner = -1;
  int m_last  = N_REQ - 1;
  int m_held  = 0;

  function automatic int pick(
    input logic [N_REQ-1:0] req
  );
    for (int k = 1; k <= N_REQ; k++) begin
      if (req[(m_last + k) % N_REQ])
        return (m_last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model(
    input  bit               en,
    input  logic [N_REQ-1:0] req,
    input  bit               rel,
    output exp_t             e
  );
    e.code = 0;
    e.tmo  = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (rel || !req[m_owner]) begin
        m_owner = -1;
      end else if (MH != 0 && m_held == MH) begin
        m_owner = -1;
        e.tmo   = 1'b1;
      end else begin
        e.code = m_owner + 1;
      end
    end else if (en) begin
      int w;
      w = pick(req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 0;
        e.code  = w + 1;
      end
    end
  endtask

  // Called at negedge+1; inputs then meet the next posedge
  task automatic cycle(
    input bit               en,
    input logic [N_REQ-1:0] req,
    input bit               rel
  );
    exp_t e;
    u_if.i_en      = en;
    u_if.i_req     = req;
    u_if.i_release = rel;
    model(en, req, rel, e);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (u_if.o_grant_code !== '0 ||
        u_if.o_grant !== '0 ||
        u_if.o_valid !== 1'b0 ||
        u_if.o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: code=%0d oh=%h v=%b to=%b, want all 0",
               name, u_if.o_grant_code, u_if.o_grant,
               u_if.o_valid, u_if.o_timeout);
    end
  endtask

  task automatic do_reset;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_zero("async_reset");
    u_if.i_en      = 1'b1;
    u_if.i_req     = '1;
    u_if.i_release = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    #1;
    rst_n   = 1'b1;
    m_owner = -1;
    m_last  = N_REQ - 1;
    m_held  = 0;
    q.delete();
    mon_en  = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t             e;
    logic [N_REQ-1:0] oh;
    if (mon_en && q.size() > 0) begin
      e  = q.pop_front();
      oh = '0;
      if (e.code != 0) oh[e.code - 1] = 1'b1;
      n_tests++;
      if (u_if.o_grant_code !== CODE_W'(e.code) ||
          u_if.o_grant !== oh ||
          u_if.o_valid !== (e.code != 0) ||
          u_if.o_timeout !== e.tmo) begin
        n_fail++;
        $display("FAIL grant @%0t: code=%0d oh=%h v=%b to=%b, want code=%0d oh=%h v=%b to=%b",
                 $time, u_if.o_grant_code, u_if.o_grant,
                 u_if.o_valid, u_if.o_timeout,
                 e.code, oh, e.code != 0, e.tmo);
      end
    end
  end

  initial begin
    logic [N_REQ-1:0] rq;
    u_if.i_en      = 1'b0;
    u_if.i_req     = '0;
    u_if.i_release = 1'b0;
    @(negedge clk);
    #1;

    // All requesting out of reset: requester 0 first
    do_reset();
    repeat (3) cycle(1'b1, 10'h3FF, 1'b0);
    cycle(1'b1, 10'h3FF, 1'b1);
    repeat (2) cycle(1'b1, 10'h3FF, 1'b0);

    // Single requester, explicit release, then idle
    do_reset();
    repeat (3) cycle(1'b1, 10'h008, 1'b0);
    cycle(1'b1, 10'h000, 1'b1);
    repeat (3) cycle(1'b1, 10'h000, 1'b0);

    // Full rotation, release after 2 visible cycles
    do_reset();
    for (int i = 0; i < 36; i++)
      cycle(1'b1, 10'h3FF, (i % 3) == 2);

    // Watchdog on requester 5, then 7 gets served
    do_reset();
    repeat (14) cycle(1'b1, 10'h0A0, 1'b0);

    // Release coincident with the timeout cycle
    do_reset();
    repeat (4) cycle(1'b1, 10'h010, 1'b0);
    cycle(1'b1, 10'h010, 1'b1);
    repeat (2) cycle(1'b1, 10'h000, 1'b0);

    // Enable dropped during a grant of code 3
    do_reset();
    cycle(1'b1, 10'h004, 1'b0);
    cycle(1'b0, 10'h004, 1'b0);
    cycle(1'b0, 10'h004, 1'b1);
    repeat (3) cycle(1'b0, 10'h004, 1'b0);
    repeat (3) cycle(1'b1, 10'h004, 1'b0);

    // Implicit release, then reset mid-grant
    do_reset();
    repeat (2) cycle(1'b1, 10'h204, 1'b0);
    cycle(1'b1, 10'h200, 1'b0);
    repeat (3) cycle(1'b1, 10'h200, 1'b0);
    do_reset();

    // Random traffic
    rq = 10'($urandom);
    for (int i = 0; i < 800; i++) begin
      rq = rq ^ (10'($urandom) & 10'($urandom)
                 & 10'($urandom));
      cycle($urandom_range(0, 9) != 0, rq,
            $urandom_range(0, 5) == 0);
    end
    do_reset();
    repeat (2) cycle(1'b1, 10'h3FF, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter10.md
Name: rr_arbiter10

Overview:
Round-robin arbiter sharing one 10-way one-hot select resource between 10 requesters. It issues a registered 4-bit grant code using the team's 1..10 code convention: code k+1 selects requester k, and 0 means no selection. The same grant is also provided as a one-hot vector. It sits directly upstream of the 4-to-10 one-hot decode stage and sequences ownership with a hold/release handshake and a watchdog timeout.

Parameters:
N_REQ, 10, number of requesters; fixed at 10, and the code width depends on it.
CODE_W, 4, width of the grant code.
MAX_HOLD, 16, maximum cycles a grant may be held before forced revocation; 0 disables the timeout.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_en  input  1  arbitration enable; when low, no new grants are issued.
i_req  input  10  request vector; bit k is requester k, level-sensitive.
i_release  input  1  current owner releases the grant; sampled only in GRANT.
o_grant_code  output  4  registered grant code; 0 = none, 1..10 = requester 0..9.
o_grant  output  10  registered one-hot grant; equals the decode of o_grant_code, all-zero when code is 0.
o_valid  output  1  high when a grant is active (o_grant_code != 0).
o_timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_grant_code = 0, o_grant = 0, o_valid = 0, o_timeout = 0.
  - state = IDLE, hold counter = 0.
  - last-grant pointer = 9, so requester 0 has top priority first.
- States: IDLE, GRANT, GAP.
- IDLE: if i_en && |i_req, pick the first set bit scanning circularly from (pointer+1) mod 10.
  - Register the grant; next state GRANT.
  - Latency: request sampled at edge t gives grant visible after edge t+1.
  - Otherwise stay in IDLE with all outputs 0.
- GRANT: outputs hold the granted code and one-hot; the hold counter increments every cycle.
  - Exit to GAP when i_release = 1, or when the owner's i_req bit = 0 (implicit release), or on timeout.
  - Timeout fires when MAX_HOLD != 0 and the counter reaches MAX_HOLD-1, i.e. after the grant has been visible for MAX_HOLD cycles. o_timeout pulses for exactly 1 cycle, coincident with entering GAP.
  - i_release or implicit release in the same cycle as timeout: treated as a normal release, no o_timeout pulse.
  - The pointer is updated to the granted index when the grant is issued.
- GAP: exactly 1 cycle with o_grant_code = 0, o_grant = 0, o_valid = 0, so the downstream select is never switched owner-to-owner without a dead cycle.
  - GAP arbitrates with the same rule as IDLE: next state GRANT if a winner exists, else IDLE.
  - The releasing requester has lowest priority if it re-requests.
  - Release sampled at edge t: outputs low after t+1, next grant visible after t+2.
- i_en low: no new grants from IDLE or GAP. An existing grant continues until released or timed out.
- Grant code is never 11..15. o_grant always has at most one bit set and is consistent with the code in every cycle.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge. No o_timeout pulse.
- The hold counter is $clog2(MAX_HOLD+1) bits wide and saturates. It clears on every new grant.

Decomposition:
- Shared package: N_REQ, CODE_W, CODE_NONE = 0, and the state encoding (IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2).
- One sub-module: rr_pick10. It is a combinational circular-priority picker with inputs req[9:0] and ptr[3:0], and outputs idx[3:0] and hit. It is reused by IDLE and GAP.
- Code-to-one-hot conversion uses the existing 4-to-10 decode convention, mapping code k+1 to bit k.

Test Plan:
1. Reset with i_req = 10'h3FF, i_en = 1 held: all outputs 0 during reset. The first edge after release arbitrates, and the following cycle shows o_grant_code = 1, o_grant = 10'h001.
2. Single request i_req = 10'h008: o_grant_code = 4, o_grant = 10'h008. A 1-cycle i_release gives one GAP cycle with code 0, then IDLE.
3. All requesters held and releasing each grant after 2 cycles: codes rotate 1, 2, …, 10, 1 with exactly one zero-code GAP cycle between consecutive grants.
4. MAX_HOLD = 4, requester 5 holds with no release: code 6 for 4 cycles, then o_timeout = 1 for 1 cycle with code 0. The next grant goes to another pending requester before 5.
5. During a grant of code 3, drop i_en and then release: GAP, then IDLE with code 0 while i_en = 0. Re-raise i_en: the next eligible code appears one cycle later.
6. Owner's i_req bit drops without i_release: implicit release into GAP. Asserting i_rst_n = 0 mid-grant clears o_grant_code, o_grant and o_valid asynchronously, before the next clock edge.
